// File: rtl/pe_out_drain_pkg.sv
// Shared types and helpers for the PE output drain and related writeback paths.
package pe_out_drain_pkg;

  localparam int DEF_DATA_WIDTH = 8;

  typedef logic [2*DEF_DATA_WIDTH-1:0] result_t;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } drain_state_e;

  function automatic int tileSize(input int xDim, input int yDim);
    return xDim * yDim;
  endfunction

endpackage

// File: rtl/pe_out_drain_relu.sv
// Combinational clamp-to-zero of one signed result; shared by writeback paths.
module pe_drain_relu
  import pe_out_drain_pkg::*;
#(
  parameter int W = $bits(result_t)
) (
  input  logic         en_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o
);

  assign data_o = (en_i && data_i[W-1]) ? '0 : data_i;

endmodule

// File: rtl/pe_out_drain.sv
// Captures the whole PE result grid in one cycle, then streams it row-major
// into the output-feature buffer over a valid/ready write port.
module pe_out_drain
  import pe_out_drain_pkg::*;
#(
  parameter int X_DIM      = 5,
  parameter int Y_DIM      = 5,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_W     = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cap_valid,
  output logic                    cap_ready,
  input  logic [2*DATA_WIDTH-1:0] pe_out [X_DIM-1:0][Y_DIM-1:0],
  input  logic                    relu_en,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic                    abort,
  output logic                    of_wr_valid,
  input  logic                    of_wr_ready,
  output logic [ADDR_W-1:0]       of_wr_addr,
  output logic [2*DATA_WIDTH-1:0] of_wr_data,
  output logic                    drain_done
);

  localparam int RW   = 2 * DATA_WIDTH;
  localparam int TILE = tileSize(X_DIM, Y_DIM);
  localparam int IW   = (X_DIM > 1) ? $clog2(X_DIM) : 1;
  localparam int JW   = (Y_DIM > 1) ? $clog2(Y_DIM) : 1;
  localparam int BW   = (TILE > 1) ? $clog2(TILE) : 1;
  localparam logic [JW-1:0] J_LAST    = JW'(Y_DIM - 1);
  localparam logic [BW-1:0] BEAT_LAST = BW'(TILE - 1);

  drain_state_e    state_q, state_d;
  logic [IW-1:0]   row_q, row_d, rowNext;
  logic [JW-1:0]   col_q, col_d, colNext;
  logic [BW-1:0]   beat_q, beat_d;
  logic            relu_q, relu_d;
  logic            valid_q, valid_d;
  logic            done_q, done_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [RW-1:0]   data_q, data_d;
  logic [RW-1:0]   shadow_q [X_DIM-1:0][Y_DIM-1:0];
  logic            capture;
  logic [RW-1:0]   srcData, reluData;
  logic            srcRelu;

  always_comb begin
    colNext = col_q + JW'(1);
    rowNext = row_q;
    if (col_q == J_LAST) begin
      colNext = '0;
      rowNext = row_q + IW'(1);
    end
  end

  // The output register is loaded either straight from the grid at capture or
  // from the shadow copy for the following beat, so one clamp serves both.
  always_comb begin
    srcData = shadow_q[rowNext][colNext];
    srcRelu = relu_q;
    if (state_q == IDLE) begin
      srcData = pe_out[0][0];
      srcRelu = relu_en;
    end
  end

  pe_drain_relu #(.W(RW)) uRelu (
    .en_i   (srcRelu),
    .data_i (srcData),
    .data_o (reluData)
  );

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    beat_d  = beat_q;
    relu_d  = relu_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    capture = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cap_valid && !abort) begin
          capture = 1'b1;
          state_d = DRAIN;
          row_d   = '0;
          col_d   = '0;
          beat_d  = '0;
          relu_d  = relu_en;
          valid_d = 1'b1;
          addr_d  = base_addr;
          data_d  = reluData;
        end
      end
      DRAIN: begin
        if (abort) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end else if (valid_q && of_wr_ready) begin
          if (beat_q == BEAT_LAST) begin
            state_d = IDLE;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            row_d  = rowNext;
            col_d  = colNext;
            beat_d = beat_q + BW'(1);
            addr_d = addr_q + ADDR_W'(1);
            data_d = reluData;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      beat_q  <= '0;
      relu_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      beat_q  <= beat_d;
      relu_q  <= relu_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < X_DIM; i++)
        for (int j = 0; j < Y_DIM; j++)
          shadow_q[i][j] <= '0;
    end else if (capture) begin
      shadow_q <= pe_out;
    end
  end

  assign cap_ready   = (state_q == IDLE);
  assign of_wr_valid = valid_q;
  assign of_wr_addr  = addr_q;
  assign of_wr_data  = data_q;
  assign drain_done  = done_q;

endmodule
